// File: rtl/vector_reversal_arbiter.sv
// Round-robin arbiter in front of a shared bit-reversal datapath.
// One grant per cycle, result registered behind a valid/ready handshake.
module vector_reversal_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDW-1:0]          out_id,
    input  logic                    out_ready
);

    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[WIDTH-1-i] = v[i];
        end
        return r;
    endfunction

    logic [IDW-1:0] ptr_r;
    logic [IDW:0]   cand_s;
    logic [IDW-1:0] grant_idx_s;
    logic           grant_found_s;
    logic           can_accept_s;
    logic           xfer_s;

    // Scan from ptr with explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr_r} + (IDW+1)'(k);
            if (cand_s >= NREQ_W) begin
                cand_s = cand_s - NREQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[IDW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Acceptance gating and one-hot ready generation.
    always_comb begin
        can_accept_s = !out_valid || out_ready;
        xfer_s       = grant_found_s && can_accept_s && !reset;
        req_ready    = '0;
        if (xfer_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr_r     <= '0;
        end else if (xfer_s) begin
            out_valid <= 1'b1;
            out_data  <= reverse_bits(req_data[grant_idx_s*WIDTH +: WIDTH]);
            out_id    <= grant_idx_s;
            ptr_r     <= (grant_idx_s == LAST_ID) ? '0 : grant_idx_s + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_reversal_arbiter.sv
// Scoreboard bench for vector_reversal_arbiter: an independent grant/ptr model
// pushes expected results on transfer and compares them while they are presented.
module tb_vector_reversal_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;

    vector_reversal_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [IDW-1:0]   id;
    } res_t;

    res_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              m_ptr = 0;
    logic            m_valid = 1'b0;
    logic [NREQ-1:0] last_xfer = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: sample/compare at negedge, update model, advance past posedge.
    task automatic step();
        logic [NREQ-1:0]  exp_rr;
        logic [WIDTH-1:0] s;
        res_t             e;
        int               g;
        @(negedge clk);
        exp_rr = '0;
        g = -1;
        if (!reset && (!m_valid || out_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) exp_rr[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'(1), 32'(0));
            end else begin
                e = sb[0];
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_id", 32'(out_id), 32'(e.id));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (reset) begin
            sb.delete();
            m_valid   = 1'b0;
            m_ptr     = 0;
            last_xfer = '0;
        end else if (g >= 0) begin
            s      = req_data[g*WIDTH +: WIDTH];
            e.d    = {<<{s}};
            e.id   = IDW'(g);
            sb.push_back(e);
            m_valid   = 1'b1;
            m_ptr     = (g + 1) % NREQ;
            last_xfer = exp_rr;
        end else begin
            last_xfer = '0;
            if (m_valid && out_ready) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hA5C3_0F96;
        out_ready = 1'b1;
        #1;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'(4'b0000));
        check("rst_data", 32'(out_data), 32'(8'h00));
        check("rst_id", 32'(out_id), 32'(0));
        reset = 1'b0;

        // Single requester
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'b1100_0001, 8'h00, 8'h00};
        #1;
        check("single_rr", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = 4'b0000;
        #1;
        check("single_data", 32'(out_data), 32'(8'b1000_0011));
        check("single_id", 32'(out_id), 32'(2));
        step();

        // Fairness from reset
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
        for (int k = 0; k < 5; k++) begin
            step();
            check("fair_valid", 32'(out_valid), 32'(1));
            check("fair_id", 32'(out_id), 32'(k % 4));
            check("fair_data", 32'(out_data), 32'(8'h80 >> (k % 4)));
        end

        // Backpressure holding id 1
        step();
        check("bp_pre_id", 32'(out_id), 32'(1));
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rr", 32'(req_ready), 32'(4'b0000));
            step();
            check("bp_data", 32'(out_data), 32'(8'h40));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rr", 32'(req_ready), 32'(4'b0100));
        step();
        check("bp_next_id", 32'(out_id), 32'(2));
        check("bp_no_bubble", 32'(out_valid), 32'(1));

        // Pointer wrap
        step();
        check("wrap_g3", 32'(out_id), 32'(3));
        req_valid = 4'b1010;
        step();
        check("wrap_a", 32'(out_id), 32'(1));
        step();
        check("wrap_b", 32'(out_id), 32'(3));
        step();
        check("wrap_c", 32'(out_id), 32'(1));

        // Reset mid-operation under backpressure
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'(0));
        check("midrst_data", 32'(out_data), 32'(8'h00));
        out_ready = 1'b1;
        #1;
        check("midrst_first", 32'(req_ready), 32'(4'b0010));
        step();

        // Random traffic respecting the hold rule for ungranted requesters
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_xfer[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 60) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        check("drain", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
